// File: rtl/dout_capture_tx_pkg.sv
// Shared types and constants for the Dout/Dval capture UART transmitter.
// Holds the transmit FSM encodings and the default bit period.
package dout_capture_tx_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 434;
  localparam int BAUD_W               = 16;
  localparam int BIT_CNT_W            = 3;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  // Terminal value of the baud counter for a given bit period.
  function automatic logic [BAUD_W-1:0] baud_max(input int clks_per_bit);
    return BAUD_W'(clks_per_bit - 1);
  endfunction

endpackage

// File: rtl/dout_capture_tx_sync_fifo.sv
// Small synchronous FIFO with registered read data and an occupancy count.
// Pointers carry one extra wrap bit so that full and empty are distinguishable.
module sync_fifo
  import dout_capture_tx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop frees a slot in the same cycle, so a full FIFO still takes a push alongside it.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rdata  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        rdata  <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/dout_capture_tx.sv
// Captures Dout on each rising edge of Dval into a FIFO and sends the queued
// bytes LSB-first as 8N1 UART frames on Tx.
module dout_capture_tx
  import dout_capture_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_AW      = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [7:0]       Dout,
  input  logic             Dval,
  output logic             Tx,
  output logic             Busy,
  output logic             Overflow,
  output logic [FIFO_AW:0] Count
);

  localparam logic [BAUD_W-1:0] BAUD_MAX = baud_max(CLKS_PER_BIT);

  tx_state_t            state;
  tx_state_t            state_next;
  logic                 dval_q;
  logic                 push;
  logic                 pop;
  logic [7:0]           fifo_rdata;
  logic [FIFO_AW:0]     fifo_count;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [BAUD_W-1:0]    baud_cnt;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [7:0]           shifter;
  logic                 baud_done;
  logic                 tx_next;

  // dval_q resets high so a Dval level held across reset is not taken as a new byte.
  always_ff @(posedge Clock) begin
    if (Reset) dval_q <= 1'b1;
    else       dval_q <= Dval;
  end

  assign push = Dval & ~dval_q;

  always_ff @(posedge Clock) begin
    if (Reset)                            Overflow <= 1'b0;
    else if (push && fifo_full && !pop)   Overflow <= 1'b1;
  end

  sync_fifo #(
    .WIDTH (8),
    .AW    (FIFO_AW)
  ) u_fifo (
    .Clock (Clock),
    .Reset (Reset),
    .push  (push),
    .pop   (pop),
    .wdata (Dout),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign baud_done = (baud_cnt == BAUD_MAX);

  always_ff @(posedge Clock) begin
    if (Reset) state <= TX_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      TX_IDLE:  if (!fifo_empty)                    state_next = TX_START;
      TX_START: if (baud_done)                      state_next = TX_DATA;
      TX_DATA:  if (baud_done && bit_cnt == 3'd7)   state_next = TX_STOP;
      TX_STOP:  if (baud_done)                      state_next = TX_IDLE;
      default:                                      state_next = TX_IDLE;
    endcase
  end

  always_comb begin
    pop     = 1'b0;
    tx_next = 1'b1;
    case (state)
      TX_IDLE:  pop     = ~fifo_empty;
      TX_START: tx_next = 1'b0;
      TX_DATA:  tx_next = shifter[0];
      TX_STOP:  tx_next = 1'b1;
      default:  tx_next = 1'b1;
    endcase
  end

  // The FIFO read data lands one cycle after the pop, so the shifter is
  // loaded from it as the start bit ends rather than in IDLE itself.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Tx       <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shifter  <= '0;
    end else begin
      Tx <= tx_next;
      if (state == TX_IDLE) begin
        baud_cnt <= '0;
        bit_cnt  <= '0;
      end else begin
        baud_cnt <= baud_done ? '0 : baud_cnt + 16'd1;
        if (state == TX_START && baud_done) shifter <= fifo_rdata;
        if (state == TX_DATA && baud_done) begin
          shifter <= shifter >> 1;
          bit_cnt <= bit_cnt + 3'd1;
        end
      end
    end
  end

  assign Busy  = (state != TX_IDLE) | (fifo_count != '0);
  assign Count = fifo_count;

endmodule

// File: tb/tb_dout_capture_tx.sv
// Self-checking bench for dout_capture_tx: directed scenarios plus random
// Dval/Dout traffic, compared every cycle against a frame-timing model.
module tb_dout_capture_tx;

  localparam int CPB   = 4;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int FRAME = 10 * CPB;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [7:0]  Dout;
  logic        Dval;
  logic        Tx;
  logic        Busy;
  logic        Overflow;
  logic [AW:0] Count;

  int checkCount = 0;
  int errorCount = 0;
  int peakCount  = 0;

  dout_capture_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_AW      (AW)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Dout     (Dout),
    .Dval     (Dval),
    .Tx       (Tx),
    .Busy     (Busy),
    .Overflow (Overflow),
    .Count    (Count)
  );

  always #5 Clock = ~Clock;

  // Reference: a byte queue plus a "line busy for FRAME cycles" timer; Tx is
  // derived from how far into the current frame the timer says we are.
  logic [7:0] modelQ[$];
  int         txLeft    = 0;
  logic [7:0] frameByte = 8'h00;
  logic       prevDval  = 1'b1;
  logic       expTx     = 1'b1;
  logic       expOvf    = 1'b0;

  always @(posedge Clock) begin
    int  k, idx, sizeBefore;
    bit  pushM, popM;
    if (Reset) begin
      modelQ.delete();
      txLeft   = 0;
      prevDval = 1'b1;
      expOvf   = 1'b0;
      expTx    = 1'b1;
    end else begin
      if (txLeft > 0) begin
        k   = FRAME - txLeft;
        idx = k / CPB;
        if (idx == 0)      expTx = 1'b0;
        else if (idx == 9) expTx = 1'b1;
        else               expTx = frameByte[idx-1];
      end else begin
        expTx = 1'b1;
      end
      pushM      = Dval && !prevDval;
      prevDval   = Dval;
      sizeBefore = modelQ.size();
      popM       = (txLeft == 0) && (sizeBefore != 0);
      if (popM) begin
        frameByte = modelQ.pop_front();
        txLeft    = FRAME;
      end else if (txLeft > 0) begin
        txLeft = txLeft - 1;
      end
      if (pushM) begin
        if (sizeBefore < DEPTH || popM) modelQ.push_back(Dout);
        else                            expOvf = 1'b1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkCycle();
    checkOutput("tx", 32'(Tx), 32'(expTx));
    checkOutput("busy", 32'(Busy), 32'((txLeft != 0) || (modelQ.size() != 0)));
    checkOutput("overflow", 32'(Overflow), 32'(expOvf));
    checkOutput("count", 32'(Count), 32'(modelQ.size()));
    if (int'(Count) > peakCount) peakCount = int'(Count);
  endtask

  task automatic applyStimulus(input logic rst, input logic dval, input logic [7:0] dout, input int cycles);
    Reset = rst;
    Dval  = dval;
    Dout  = dout;
    repeat (cycles) begin
      @(posedge Clock);
      #1;
      checkCycle();
    end
  endtask

  initial begin
    Reset = 1'b1;
    Dval  = 1'b0;
    Dout  = 8'h00;

    $display("[TB] reset");
    applyStimulus(1'b1, 1'b0, 8'h00, 3);
    checkOutput("rst_tx", 32'(Tx), 32'd1);
    checkOutput("rst_busy", 32'(Busy), 32'd0);
    checkOutput("rst_overflow", 32'(Overflow), 32'd0);
    checkOutput("rst_count", 32'(Count), 32'd0);

    $display("[TB] single byte 0xA5");
    applyStimulus(1'b0, 1'b1, 8'hA5, 2);
    applyStimulus(1'b0, 1'b0, 8'h00, 48);
    checkOutput("single_idle_busy", 32'(Busy), 32'd0);

    $display("[TB] held level 0x3C");
    applyStimulus(1'b0, 1'b1, 8'h3C, 200);
    checkOutput("held_count", 32'(Count), 32'd0);
    applyStimulus(1'b0, 1'b0, 8'h00, 5);

    $display("[TB] overflow burst");
    peakCount = 0;
    for (int i = 0; i < 18; i++) begin
      applyStimulus(1'b0, 1'b1, 8'(i), 1);
      applyStimulus(1'b0, 1'b0, 8'(i), 1);
    end
    checkOutput("ovf_peak", 32'(peakCount), 32'd16);
    checkOutput("ovf_flag", 32'(Overflow), 32'd1);
    applyStimulus(1'b0, 1'b0, 8'h00, 17 * (FRAME + 1) + 10);
    checkOutput("ovf_drained", 32'(Busy), 32'd0);
    checkOutput("ovf_sticky", 32'(Overflow), 32'd1);

    $display("[TB] reset mid-frame");
    applyStimulus(1'b1, 1'b0, 8'h00, 2);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 8'h50 + 8'(i), 1);
      applyStimulus(1'b0, 1'b0, 8'h00, 1);
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 8);
    applyStimulus(1'b1, 1'b0, 8'h00, 1);
    checkOutput("mid_tx", 32'(Tx), 32'd1);
    checkOutput("mid_count", 32'(Count), 32'd0);
    applyStimulus(1'b0, 1'b0, 8'h00, 60);
    checkOutput("mid_busy", 32'(Busy), 32'd0);

    $display("[TB] dval through reset");
    applyStimulus(1'b0, 1'b1, 8'h77, 1);
    applyStimulus(1'b0, 1'b0, 8'h00, FRAME + 4);
    applyStimulus(1'b0, 1'b1, 8'h99, 1);
    applyStimulus(1'b1, 1'b1, 8'h99, 2);
    applyStimulus(1'b0, 1'b1, 8'h99, 30);
    checkOutput("dval_rst_busy", 32'(Busy), 32'd0);
    applyStimulus(1'b0, 1'b0, 8'h00, 2);
    applyStimulus(1'b0, 1'b1, 8'hC3, 2);
    applyStimulus(1'b0, 1'b0, 8'h00, FRAME + 5);

    $display("[TB] random traffic");
    for (int i = 0; i < 500; i++) begin
      logic rst;
      rst = ($urandom_range(0, 249) == 0);
      applyStimulus(rst, 1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(1, 6));
    end
    applyStimulus(1'b0, 1'b0, 8'h00, DEPTH * (FRAME + 1) + 20);
    checkOutput("final_busy", 32'(Busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
